trace_stream_packer: RTL and testbench

- Downstream neighbour of the trace AXI-stream source. It consumes 96-bit trace packets {pc[63:0], instr[31:0]} and repacks them densely into 64-bit AXI-stream beats for the DMA/FIFO path.
- Two packets become three beats, with no padding except when a packet ends a transfer on an odd boundary.
- Preserves tlast framing and exposes packet/beat counters for the Python-side driver.

---
 rtl/trace_stream_packer_if.sv | 30 +++
 rtl/trace_stream_packer.sv | 165 ++++++++++++++++
 tb/tb_trace_stream_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_stream_packer_if.sv
// AXI-stream signal bundle used on both sides of trace_stream_packer.
// The tkeep lane exists only when TRACE_STREAM_PACKER_TKEEP_EN is defined.
interface trace_stream_packer_if #(
   parameter int unsigned DATA_W = 64
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
   logic [7:0]        tkeep;
`endif

   modport master (
      output tvalid,
      output tdata,
      output tlast,
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
      output tkeep,
`endif
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/trace_stream_packer.sv
// Packs 96-bit {pc, instr} trace packets densely into 64-bit AXI-stream beats.
// Optional tkeep output enabled by defining TRACE_STREAM_PACKER_TKEEP_EN.
module trace_stream_packer #(
   parameter int unsigned XLEN     = 64,
   parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   trace_stream_packer_if.slave  S_AXIS,
   trace_stream_packer_if.master M_AXIS,
   output logic [31:0]           packets_accepted,
   output logic [31:0]           beats_sent
);

   localparam int unsigned PKT_W = XLEN + 32;

   typedef enum logic [1:0] {
      PH0,
      PH1,
      PH2,
      PH_PAD
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [PKT_W-1:0] pkt;
   logic             out_free;
   logic             s_ready;
   logic             s_hs;
   logic             m_hs;
   logic             load;

   logic             out_valid_q;
   logic             out_valid_d;
   logic [63:0]      out_data_q;
   logic [63:0]      out_data_d;
   logic             out_last_q;
   logic             out_last_d;

   logic [31:0]      res32_q;
   logic [31:0]      res32_d;
   logic [63:0]      res64_q;
   logic [63:0]      res64_d;
   logic             blast_q;
   logic             blast_d;

   logic [31:0]      pkt_cnt;
   logic [31:0]      beat_cnt;

   assign pkt      = S_AXIS.tdata;
   assign out_free = ~out_valid_q | M_AXIS.tready;
   assign m_hs     = out_valid_q & M_AXIS.tready;

   always_comb begin
      state_d    = state_q;
      s_ready    = 1'b0;
      s_hs       = 1'b0;
      load       = 1'b0;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      res32_d    = res32_q;
      res64_d    = res64_q;
      blast_d    = blast_q;

      unique case (state_q)
         PH0: begin
            s_ready = out_free;
            s_hs    = s_ready & S_AXIS.tvalid;
            if (s_hs) begin
               load       = 1'b1;
               out_data_d = pkt[63:0];
               out_last_d = 1'b0;
               res32_d    = pkt[95:64];
               state_d    = S_AXIS.tlast ? PH_PAD : PH1;
            end
         end

         PH1: begin
            s_ready = out_free;
            s_hs    = s_ready & S_AXIS.tvalid;
            if (s_hs) begin
               load       = 1'b1;
               out_data_d = {pkt[31:0], res32_q};
               out_last_d = 1'b0;
               res64_d    = pkt[95:32];
               blast_d    = S_AXIS.tlast;
               state_d    = PH2;
            end
         end

         // Flush the 64-bit residue; upstream is stalled for this one beat.
         PH2: begin
            if (out_free) begin
               load       = 1'b1;
               out_data_d = res64_q;
               out_last_d = blast_q;
               state_d    = PH0;
            end
         end

         PH_PAD: begin
            if (out_free) begin
               load       = 1'b1;
               out_data_d = {PAD_WORD, res32_q};
               out_last_d = 1'b1;
               state_d    = PH0;
            end
         end

         default: state_d = PH0;
      endcase

      out_valid_d = load | (out_valid_q & ~out_free);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= PH0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         res32_q     <= '0;
         res64_q     <= '0;
         blast_q     <= 1'b0;
         pkt_cnt     <= '0;
         beat_cnt    <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res32_q     <= res32_d;
         res64_q     <= res64_d;
         blast_q     <= blast_d;
         if (load) begin
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
         end
         if (s_hs) pkt_cnt  <= pkt_cnt + 32'd1;
         if (m_hs) beat_cnt <= beat_cnt + 32'd1;
      end
   end

`ifdef TRACE_STREAM_PACKER_TKEEP_EN
   logic [7:0] out_keep_q;

   // Only the pad beat leaves the upper 32 bits empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_keep_q <= '0;
      end else if (load) begin
         out_keep_q <= (state_q == PH_PAD) ? 8'h0F : 8'hFF;
      end
   end

   assign M_AXIS.tkeep = out_keep_q;
`endif

   assign S_AXIS.tready    = s_ready;
   assign M_AXIS.tvalid    = out_valid_q;
   assign M_AXIS.tdata     = out_data_q;
   assign M_AXIS.tlast     = out_last_q;
   assign packets_accepted = pkt_cnt;
   assign beats_sent       = beat_cnt;

endmodule

// File: tb/tb_trace_stream_packer.sv
// Self-checking bench for trace_stream_packer: directed table, corner-case
// sequences and randomized traffic checked against a word-stream model.
module tb_trace_stream_packer;

   localparam logic [31:0] PAD = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] packets_accepted;
   logic [31:0] beats_sent;

   trace_stream_packer_if #(.DATA_W(96)) s_if ();
   trace_stream_packer_if #(.DATA_W(64)) m_if ();

   trace_stream_packer #(
      .XLEN     (64),
      .PAD_WORD (PAD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .S_AXIS           (s_if),
      .M_AXIS           (m_if),
      .packets_accepted (packets_accepted),
      .beats_sent       (beats_sent)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [7:0]  keep;
   } beat_t;

   typedef struct {
      logic [95:0] data;
      logic        last;
      int unsigned nb;
      logic [63:0] b[2];
      logic        l[2];
      logic [7:0]  k[2];
   } vec_t;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [31:0] wq[$];
   beat_t       expq[$];
   beat_t       got[$];
   logic [31:0] exp_pkts = '0;
   logic [31:0] exp_beats = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the input is a stream of 32-bit words (instr, pc_lo, pc_hi);
   // beats are consecutive word pairs, a frame ending on an odd word is padded.
   task automatic model_push(input logic [95:0] d, input logic l);
      logic [31:0] lo;
      logic [31:0] hi;
      beat_t       bt;
      wq.push_back(d[31:0]);
      wq.push_back(d[63:32]);
      wq.push_back(d[95:64]);
      while (wq.size() >= 2) begin
         lo = wq.pop_front();
         hi = wq.pop_front();
         bt.data = {hi, lo};
         bt.last = l && (wq.size() == 0);
         bt.keep = 8'hFF;
         expq.push_back(bt);
      end
      if (l && wq.size() == 1) begin
         lo = wq.pop_front();
         bt.data = {PAD, lo};
         bt.last = 1'b1;
         bt.keep = 8'h0F;
         expq.push_back(bt);
      end
   endtask

   always @(negedge clk) begin
      beat_t b;
      beat_t e;
      if (!rst_n) begin
         wq.delete();
         expq.delete();
         exp_pkts  = '0;
         exp_beats = '0;
      end else begin
         if (s_if.tvalid && s_if.tready) begin
            model_push(s_if.tdata, s_if.tlast);
            exp_pkts = exp_pkts + 32'd1;
         end
         if (m_if.tvalid && m_if.tready) begin
            exp_beats = exp_beats + 32'd1;
            b.data = m_if.tdata;
            b.last = m_if.tlast;
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
            b.keep = m_if.tkeep;
`else
            b.keep = 8'h00;
`endif
            got.push_back(b);
            if (expq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h with no beat expected at %0t", b.data, $time);
            end else begin
               e = expq.pop_front();
               check("model_tdata", b.data, e.data);
               check("model_tlast", 64'(b.last), 64'(e.last));
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
               check("model_tkeep", 64'(b.keep), 64'(e.keep));
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [95:0] d, input logic l);
      int unsigned n = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      @(negedge clk);
      while (!s_if.tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_if.tready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: tready stayed %b, required 1", s_if.tready);
      end
      tick();
   endtask

   function automatic logic [95:0] rand_pkt();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      vec_t        tbl[3];
      int unsigned gi;
      logic [63:0] held;
      logic [31:0] pa;
      logic [31:0] bs;
      logic [95:0] pk;
      logic        hs;
      int unsigned k;

      tbl[0].data = {64'h0000_0000_8000_0004, 32'h0000_0013};
      tbl[0].last = 1'b0;
      tbl[0].nb   = 1;
      tbl[0].b[0] = 64'h8000_0004_0000_0013; tbl[0].l[0] = 1'b0; tbl[0].k[0] = 8'hFF;
      tbl[0].b[1] = '0;                       tbl[0].l[1] = 1'b0; tbl[0].k[1] = 8'h00;
      tbl[1].data = {64'h0000_0000_8000_0008, 32'h00A0_0093};
      tbl[1].last = 1'b1;
      tbl[1].nb   = 2;
      tbl[1].b[0] = 64'h00A0_0093_0000_0000; tbl[1].l[0] = 1'b0; tbl[1].k[0] = 8'hFF;
      tbl[1].b[1] = 64'h0000_0000_8000_0008; tbl[1].l[1] = 1'b1; tbl[1].k[1] = 8'hFF;
      tbl[2].data = {64'h1234_5678_9ABC_DEF0, 32'h0000_0001};
      tbl[2].last = 1'b1;
      tbl[2].nb   = 2;
      tbl[2].b[0] = 64'h9ABC_DEF0_0000_0001; tbl[2].l[0] = 1'b0; tbl[2].k[0] = 8'hFF;
      tbl[2].b[1] = 64'h0000_0000_1234_5678; tbl[2].l[1] = 1'b1; tbl[2].k[1] = 8'h0F;

      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("rst_m_tdata", m_if.tdata, 64'd0);
      check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
      check("rst_packets", 64'(packets_accepted), 64'd0);
      check("rst_beats", 64'(beats_sent), 64'd0);
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
      check("rst_tkeep", 64'(m_if.tkeep), 64'h00);
`endif
      rst_n = 1'b1;
      tick();
      check("idle_s_tready", 64'(s_if.tready), 64'd1);

      // Directed table: pair packing then odd tlast
      got.delete();
      send_pkt(tbl[0].data, tbl[0].last);
      send_pkt(tbl[1].data, tbl[1].last);
      s_if.tvalid = 1'b0;
      repeat (4) tick();
      check("pair_packets", 64'(packets_accepted), 64'd2);
      check("pair_beats", 64'(beats_sent), 64'd3);
      send_pkt(tbl[2].data, tbl[2].last);
      s_if.tvalid = 1'b0;
      repeat (4) tick();
      gi = 0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < int'(tbl[i].nb); j++) begin
            if (gi >= got.size()) begin
               n_tests++;
               n_fail++;
               $display("FAIL table_missing: vector %0d beat %0d got none, required %h", i, j, tbl[i].b[j]);
            end else begin
               check("table_tdata", got[gi].data, tbl[i].b[j]);
               check("table_tlast", 64'(got[gi].last), 64'(tbl[i].l[j]));
`ifdef TRACE_STREAM_PACKER_TKEEP_EN
               check("table_tkeep", 64'(got[gi].keep), 64'(tbl[i].k[j]));
`endif
            end
            gi++;
         end
      end
      check("table_beat_count", 64'(got.size()), 64'd5);

      // Streaming: six back-to-back packets, S tready 1,1,0 and nine solid beats
      k = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = rand_pkt();
      s_if.tlast  = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check("stream_s_tready", 64'(s_if.tready), 64'((c % 3) != 2));
         check("stream_m_tvalid", 64'(m_if.tvalid), 64'(c >= 1));
         hs = s_if.tready;
         tick();
         if (hs) begin
            k++;
            if (k < 6) begin
               s_if.tdata = rand_pkt();
               s_if.tlast = (k == 5);
            end else begin
               s_if.tvalid = 1'b0;
            end
         end
      end
      @(negedge clk);
      check("stream_last_beat_valid", 64'(m_if.tvalid), 64'd1);
      tick();
      @(negedge clk);
      check("stream_idle_after", 64'(m_if.tvalid), 64'd0);
      tick();

      // Backpressure in PH1
      m_if.tready = 1'b0;
      send_pkt(rand_pkt(), 1'b0);
      s_if.tvalid = 1'b1;
      s_if.tdata  = rand_pkt();
      s_if.tlast  = 1'b1;
      held = m_if.tdata;
      pa   = packets_accepted;
      bs   = beats_sent;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_tdata_hold", m_if.tdata, held);
         check("bp_s_tready", 64'(s_if.tready), 64'd0);
         check("bp_packets", 64'(packets_accepted), 64'(pa));
         check("bp_beats", 64'(beats_sent), 64'(bs));
         tick();
      end
      m_if.tready = 1'b1;
      send_pkt(s_if.tdata, 1'b1);
      s_if.tvalid = 1'b0;
      repeat (5) tick();
      check("bp_drained", 64'(expq.size()), 64'd0);
      check("bp_packets_model", 64'(packets_accepted), 64'(exp_pkts));
      check("bp_beats_model", 64'(beats_sent), 64'(exp_beats));

      // Reset while a PH2 beat is pending
      send_pkt(rand_pkt(), 1'b0);
      send_pkt(rand_pkt(), 1'b0);
      s_if.tvalid = 1'b0;
      check("pre_rst_m_tvalid", 64'(m_if.tvalid), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("midrst_packets", 64'(packets_accepted), 64'd0);
      check("midrst_beats", 64'(beats_sent), 64'd0);
      tick();
      check("midrst_no_emit", 64'(m_if.tvalid), 64'd0);
      pk = rand_pkt();
      send_pkt(pk, 1'b0);
      check("midrst_fresh_ph0", m_if.tdata, pk[63:0]);
      send_pkt(rand_pkt(), 1'b1);
      s_if.tvalid = 1'b0;
      repeat (4) tick();

      // Counter wrap
      force dut.pkt_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt;
      exp_pkts = 32'hFFFF_FFFF;
      check("wrap_preload", 64'(packets_accepted), 64'hFFFF_FFFF);
      send_pkt(rand_pkt(), 1'b1);
      s_if.tvalid = 1'b0;
      repeat (3) tick();
      check("wrap_packets", 64'(packets_accepted), 64'd0);

      // Randomized traffic with random gaps and backpressure
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         hs = s_if.tvalid && s_if.tready;
         tick();
         if (hs || !s_if.tvalid) begin
            if ($urandom_range(0, 3) != 0) begin
               s_if.tvalid = 1'b1;
               s_if.tdata  = rand_pkt();
               s_if.tlast  = ($urandom_range(0, 3) == 0);
            end else begin
               s_if.tvalid = 1'b0;
            end
         end
         m_if.tready = ($urandom_range(0, 3) != 0);
      end
      m_if.tready = 1'b1;
      for (int c = 0; c < 20 && s_if.tvalid; c++) begin
         @(negedge clk);
         hs = s_if.tvalid && s_if.tready;
         tick();
         if (hs) s_if.tvalid = 1'b0;
      end
      check("rand_s_settled", 64'(s_if.tvalid), 64'd0);
      repeat (6) tick();
      check("rand_drained", 64'(expq.size()), 64'd0);
      check("rand_packets", 64'(packets_accepted), 64'(exp_pkts));
      check("rand_beats", 64'(beats_sent), 64'(exp_beats));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
